// File: rtl/illegal_instruction_exception_unit.sv
// illegal_instruction_exception_unit: holds an illegal decode instruction until the pipeline drains, then raises a precise cause-2 exception
// Optional trap value capture of the instruction word is enabled by defining ILLEGAL_TVAL_EN.
module illegal_instruction_exception_unit #(
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            decode_valid,
    input  logic [31:0]     decode_instruction,
    input  logic [31:0]     decode_pc,
    input  logic [ID_W-1:0] decode_id,
    input  logic            illegal_instruction,
    input  logic            inflight_empty,
    input  logic            gc_flush,
    input  logic            exception_ack,
    output logic            block_issue,
    output logic            decode_stall,
    output logic            exception_valid,
    output logic [4:0]      exception_code,
    output logic [31:0]     exception_pc,
    output logic [31:0]     exception_tval,
    output logic [ID_W-1:0] exception_id
);
    typedef enum logic [1:0] {IDLE, PENDING, RAISED} state_t;
    state_t state, state_nxt;
    logic capture;
    logic [31:0] pc_q;
    logic [ID_W-1:0] id_q;
    assign capture = (state == IDLE) && decode_valid && illegal_instruction && !gc_flush;
    assign block_issue = decode_valid && illegal_instruction && (state == IDLE);
    assign decode_stall = (state != IDLE);
    assign exception_valid = (state == RAISED);
    assign exception_code = exception_valid ? 5'd2 : 5'd0;
    assign exception_pc = exception_valid ? pc_q : 32'd0;
    assign exception_id = exception_valid ? id_q : '0;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    // next state: flush wins over everything, including a simultaneous ack
    always_comb begin
        state_nxt = gc_flush ? IDLE :
                    capture ? PENDING :
                    (state == PENDING && inflight_empty) ? RAISED :
                    (state == RAISED && exception_ack) ? IDLE : state;
    end
    // latch the faulting instruction's PC and ID at capture
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= 32'd0;
            id_q <= '0;
        end else if (capture) begin
            pc_q <= decode_pc;
            id_q <= decode_id;
        end
    end
`ifdef ILLEGAL_TVAL_EN
    logic [31:0] insn_q;
    // latch the faulting instruction word as trap value
    always_ff @(posedge clk) begin
        if (rst) insn_q <= 32'd0;
        else if (capture) insn_q <= decode_instruction;
    end
    assign exception_tval = exception_valid ? insn_q : 32'd0;
`else
    logic unused_insn;
    assign unused_insn = ^decode_instruction;
    assign exception_tval = 32'd0;
`endif
endmodule

// File: tb/tb_illegal_instruction_exception_unit.sv
// tb_illegal_instruction_exception_unit: per-cycle vector table checked through a scoreboard queue
module tb_illegal_instruction_exception_unit;
`ifdef ILLEGAL_TVAL_EN
    localparam logic [31:0] TVF = 32'hFFFFFFFF;
`else
    localparam logic [31:0] TVF = 32'h0;
`endif
    logic clk = 0, rst = 1, decode_valid = 0, illegal_instruction = 0, inflight_empty = 0, gc_flush = 0, exception_ack = 0;
    logic [31:0] decode_instruction = 0, decode_pc = 0;
    logic [2:0] decode_id = 0;
    logic block_issue, decode_stall, exception_valid;
    logic [4:0] exception_code;
    logic [31:0] exception_pc, exception_tval;
    logic [2:0] exception_id;
    int checks = 0, failures = 0;

    illegal_instruction_exception_unit #(.ID_W(3)) dut (
        .clk(clk), .rst(rst), .decode_valid(decode_valid), .decode_instruction(decode_instruction),
        .decode_pc(decode_pc), .decode_id(decode_id), .illegal_instruction(illegal_instruction),
        .inflight_empty(inflight_empty), .gc_flush(gc_flush), .exception_ack(exception_ack),
        .block_issue(block_issue), .decode_stall(decode_stall), .exception_valid(exception_valid),
        .exception_code(exception_code), .exception_pc(exception_pc), .exception_tval(exception_tval),
        .exception_id(exception_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, dv;
        logic [31:0] insn, pc;
        logic [2:0] id;
        logic ill, ie, fl, ack;
        logic eb, es, ev;
        logic [31:0] epc, etv;
        logic [2:0] eid;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(logic r, logic dv, logic [31:0] insn, logic [31:0] pc, logic [2:0] id,
                                logic ill, logic ie, logic fl, logic ack,
                                logic eb, logic es, logic ev, logic [31:0] epc, logic [31:0] etv, logic [2:0] eid);
        vec_t v;
        v.rst = r; v.dv = dv; v.insn = insn; v.pc = pc; v.id = id;
        v.ill = ill; v.ie = ie; v.fl = fl; v.ack = ack;
        v.eb = eb; v.es = es; v.ev = ev; v.epc = epc; v.etv = etv; v.eid = eid;
        return v;
    endfunction

    task automatic chk(input string n, input int row, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s row=%0d got=%h exp=%h", n, row, a, e);
        end
    endtask

    initial begin
        // rst dv insn pc id ill ie fl ack | eb es ev epc etv eid
        tbl.push_back(mk(0,1,32'h13,32'h80000000,0, 0,1,0,0, 0,0,0,0,0,0));          // 0 legal nop, reset state
        tbl.push_back(mk(0,1,32'h13,32'h80000004,1, 0,1,0,0, 0,0,0,0,0,0));          // 1
        tbl.push_back(mk(0,0,32'h0,32'h80000008,2, 1,1,0,0, 0,0,0,0,0,0));           // 2 ill ignored, dv=0
        tbl.push_back(mk(0,1,32'h0,32'h80000100,5, 1,1,0,0, 1,0,0,0,0,0));           // 3 basic trap capture
        tbl.push_back(mk(0,1,32'h0,32'h80000100,5, 1,1,0,0, 0,1,0,0,0,0));           // 4 pending
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,0, 0,1,1,32'h80000100,0,5));       // 5 raised
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,1, 0,1,1,32'h80000100,0,5));       // 6 ack
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,0, 0,0,0,0,0,0));                  // 7 idle
        tbl.push_back(mk(0,1,32'hFFFFFFFF,32'h80000200,3, 1,0,0,0, 1,0,0,0,0,0));    // 8 wait-for-older capture
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,0,0,0, 0,1,0,0,0,0));                  // 9
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,0,0,1, 0,1,0,0,0,0));                  // 10 ack in pending ignored
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,0,0,0, 0,1,0,0,0,0));                  // 11
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,0,0,0, 0,1,0,0,0,0));                  // 12
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,0, 0,1,0,0,0,0));                  // 13 inflight empties
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,0, 0,1,1,32'h80000200,TVF,3));     // 14 raised
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,1, 0,1,1,32'h80000200,TVF,3));     // 15 ack
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,0, 0,0,0,0,0,0));                  // 16 idle
        tbl.push_back(mk(0,1,32'h0,32'h80000300,1, 1,0,0,0, 1,0,0,0,0,0));           // 17 flush-pending capture
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,0,0,0, 0,1,0,0,0,0));                  // 18
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,0,1,0, 0,1,0,0,0,0));                  // 19 flush
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,0, 0,0,0,0,0,0));                  // 20 idle, no exception
        tbl.push_back(mk(0,1,32'h0,32'h80000380,4, 1,1,1,0, 1,0,0,0,0,0));           // 21 flush on capture cycle
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,0, 0,0,0,0,0,0));                  // 22 not captured
        tbl.push_back(mk(0,1,32'h0,32'h80000400,2, 1,1,0,0, 1,0,0,0,0,0));           // 23 capture
        tbl.push_back(mk(0,1,32'h0,32'h80000400,2, 1,1,0,0, 0,1,0,0,0,0));           // 24 pending
        tbl.push_back(mk(0,1,32'h0,32'h80000400,2, 1,1,1,1, 0,1,1,32'h80000400,0,2));// 25 ack+flush
        tbl.push_back(mk(0,1,32'hFFFFFFFF,32'h80000500,6, 1,1,0,0, 1,0,0,0,0,0));    // 26 back-to-back capture
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,0, 0,1,0,0,0,0));                  // 27 pending
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,0, 0,1,1,32'h80000500,TVF,6));     // 28 raised
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,0, 0,1,1,32'h80000500,TVF,6));     // 29 held
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,0, 0,1,1,32'h80000500,TVF,6));     // 30 held
        tbl.push_back(mk(1,0,32'h0,32'h0,0, 0,1,0,0, 0,1,1,32'h80000500,TVF,6));     // 31 reset asserted
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,0, 0,0,0,0,0,0));                  // 32 all zero
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,1, 0,0,0,0,0,0));                  // 33 ack in idle ignored
        tbl.push_back(mk(0,0,32'h0,32'h0,0, 0,1,0,0, 0,0,0,0,0,0));                  // 34
        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t e;
            @(posedge clk);
            #1;
            rst = tbl[i].rst; decode_valid = tbl[i].dv; decode_instruction = tbl[i].insn;
            decode_pc = tbl[i].pc; decode_id = tbl[i].id; illegal_instruction = tbl[i].ill;
            inflight_empty = tbl[i].ie; gc_flush = tbl[i].fl; exception_ack = tbl[i].ack;
            sb.push_back(tbl[i]);
            @(negedge clk);
            e = sb.pop_front();
            chk("block_issue", i, {31'd0, block_issue}, {31'd0, e.eb});
            chk("decode_stall", i, {31'd0, decode_stall}, {31'd0, e.es});
            chk("exception_valid", i, {31'd0, exception_valid}, {31'd0, e.ev});
            chk("exception_code", i, {27'd0, exception_code}, e.ev ? 32'd2 : 32'd0);
            chk("exception_pc", i, exception_pc, e.epc);
            chk("exception_tval", i, exception_tval, e.etv);
            chk("exception_id", i, {29'd0, exception_id}, {29'd0, e.eid});
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/illegal_instruction_exception_unit.md
# illegal_instruction_exception_unit

Decode-stage companion to the illegal-instruction checker: consumes the checker's `illegal_instruction` flag for the instruction in decode, blocks its issue, and holds it pending until all older instructions have left the pipeline. It then presents a precise illegal-instruction exception (cause 2, PC, tval) to the global control / CSR unit and holds it until acknowledged. Decode is stalled for the whole pending period.

## Interface
- `ID_W`, 3: instruction-ID width, matching decode's ID allocator.
- `clk`  in  1: core clock.
- `rst`  in  1: synchronous, active-high reset.
- `decode_valid`  in  1: decode holds a valid instruction.
- `decode_instruction`  in  32: instruction word in decode, same word driven into the checker.
- `decode_pc`  in  32: PC of the decode instruction.
- `decode_id`  in  ID_W: ID assigned to the decode instruction.
- `illegal_instruction`  in  1: checker output for `decode_instruction`.
- `inflight_empty`  in  1: no issued, unretired instructions remain.
- `gc_flush`  in  1: global flush of decode and younger state.
- `exception_ack`  in  1: global control has taken the exception.
- `block_issue`  out  1: combinational; suppress issue of the decode instruction this cycle.
- `decode_stall`  out  1: registered; decode must hold and not advance.
- `exception_valid`  out  1: exception presented.
- `exception_code`  out  5: constant 5'd2 when valid, 0 otherwise.
- `exception_pc`  out  32: PC of the faulting instruction.
- `exception_tval`  out  32: trap value (see Configuration).
- `exception_id`  out  ID_W: ID of the faulting instruction.

## Operation
- States: IDLE, PENDING, RAISED. Encoding is free; one-hot is not required.
- Capture condition: `state==IDLE & decode_valid & illegal_instruction & ~gc_flush`.
- `block_issue = decode_valid & illegal_instruction & (state==IDLE)`. In non-IDLE states, `decode_stall` already blocks issue.
- On capture: latch PC, ID, tval, and the instruction; go to PENDING.
- PENDING -> RAISED when `inflight_empty`. Minimum one cycle in PENDING.
- RAISED: `exception_valid=1`. All exception outputs are held stable. On `exception_ack`, go to IDLE.
- `gc_flush` in any state -> IDLE next cycle. The pending exception is discarded; `exception_valid` drops.
- `gc_flush` and `exception_ack` in the same cycle -> IDLE, with no double report.
- `gc_flush` in the capture cycle: no capture, and `block_issue` is still driven.
- `decode_stall=1` whenever state is not IDLE.
- Legal instructions pass through with no effect. `illegal_instruction` is ignored when `decode_valid=0`.
- Exception outputs are zero when `exception_valid=0`.

## Timing
- Reset: state IDLE. `decode_stall`, `exception_valid`, `exception_code`, `exception_pc`, `exception_tval`, `exception_id` are all 0.
- Reset mid-operation (PENDING or RAISED) returns to IDLE the next cycle, same as `gc_flush`.
- Latency: capture at cycle N. `decode_stall` is high from N+1. Earliest `exception_valid` is N+2 (inflight_empty already high at N+1).
- `exception_valid` stays high until the cycle `exception_ack` is sampled. It is low the following cycle, and `decode_stall` is low in that same cycle.
- A back-to-back illegal instruction is captured no earlier than the first IDLE cycle after ack.
- `exception_ack` outside RAISED is ignored.

## Configuration
- `ILLEGAL_TVAL_EN` defined: `exception_tval` = the faulting 32-bit instruction word. The 32-bit instruction register is implemented.
- `ILLEGAL_TVAL_EN` not defined: `exception_tval` is constant 0, as permitted by the privileged spec. The instruction register is removed.

## Test plan
- Legal pass-through: decode `0x00000013` (nop) with `illegal_instruction=0` -> `block_issue=0`, no stall, state stays IDLE.
- Basic trap: decode `0x00000000`, PC `0x80000100`, ID 5, `inflight_empty=1` -> `block_issue=1` at N, stall at N+1. At N+2: `exception_valid=1`, code 2, pc `0x80000100`, id 5, tval `0x00000000`. Ack -> IDLE the next cycle.
- Wait for older instructions: `0xFFFFFFFF` captured with `inflight_empty=0` for 4 cycles -> PENDING for 4 cycles, valid on the cycle after `inflight_empty` rises. tval is `0xFFFFFFFF` with the macro defined, 0 without.
- Flush while pending: capture, then `gc_flush` at N+2 with `inflight_empty=0` -> IDLE at N+3, `exception_valid` never asserted, stall drops.
- Ack and flush together in RAISED -> single exception reported, IDLE next cycle. A second illegal instruction presented immediately is captured in the first IDLE cycle.
- Reset in RAISED: all outputs 0 the cycle after `rst`, and held stable across 3 ack-free cycles beforehand.
